icache_refill: RTL and testbench



---
 rtl/icache_refill.sv | 110 +++++++++++
 tb/tb_icache_refill.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches a 4-word block over a 32-bit bus
// and hands the assembled 128-bit line back to the L1 controller.
module icache_refill (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         irq_i,
    input  logic [27:0]  l2_addr_i,
    input  logic         bus_busy_i,
    output logic         ic_en_o,
    output logic         l2_rdy_o,
    output logic         complete_o,
    output logic [127:0] data_wd_l2_o,
    output logic         mem_req_o,
    output logic [29:0]  mem_addr_o,
    input  logic         mem_ack_i,
    input  logic [31:0]  mem_rdata_i
);

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned BEAT_W = 2;

    typedef enum logic [2:0] {
        RF_IDLE,
        RF_WAIT_BUS,
        RF_FETCH,
        RF_RDY,
        RF_DONE
    } rf_state_e;

    rf_state_e                          state_q, state_d;
    logic [BEAT_W-1:0]                  beat_q, beat_d;
    logic [ADDR_W-1:0]                  addr_q, addr_d;
    logic [WORDS-1:0][WORD_W-1:0]       line_q, line_d;
    logic                               mem_req_q, l2_rdy_q, complete_q;

    // State and datapath registers; pulse outputs are registered off the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RF_IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            mem_req_q  <= 1'b0;
            l2_rdy_q   <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            mem_req_q  <= (state_d == RF_FETCH);
            l2_rdy_q   <= (state_d == RF_RDY);
            complete_q <= (state_d == RF_DONE);
        end
    end

    // Next-state and line-buffer update
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        unique case (state_q)
            RF_IDLE: begin
                if (irq_i) begin
                    if (!bus_busy_i) begin
                        addr_d  = l2_addr_i;
                        beat_d  = '0;
                        state_d = RF_FETCH;
                    end else begin
                        state_d = RF_WAIT_BUS;
                    end
                end
            end
            RF_WAIT_BUS: begin
                // A withdrawn request wins over a bus that just became free
                if (!irq_i) begin
                    state_d = RF_IDLE;
                end else if (!bus_busy_i) begin
                    addr_d  = l2_addr_i;
                    beat_d  = '0;
                    state_d = RF_FETCH;
                end
            end
            RF_FETCH: begin
                if (mem_ack_i) begin
                    line_d[beat_q] = mem_rdata_i;
                    beat_d         = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(WORDS - 1)) begin
                        state_d = RF_RDY;
                    end
                end
            end
            RF_RDY:  state_d = RF_DONE;
            RF_DONE: state_d = RF_IDLE;
            default: state_d = RF_IDLE;
        endcase
    end

    assign ic_en_o      = (state_q == RF_FETCH) || (state_q == RF_RDY) ||
                          (state_q == RF_DONE)  || !bus_busy_i;
    assign l2_rdy_o     = l2_rdy_q;
    assign complete_o   = complete_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = {addr_q, beat_q};
    assign data_wd_l2_o = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: stimulus pushes expected bus beats and
// handshake pulses (with their cycle numbers); a negedge monitor checks them.
module tb_icache_refill;

    localparam int K_REQ  = 0;
    localparam int K_RDY  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int           kind;
        logic [29:0]  addr;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         irq;
    logic [27:0]  l2_addr;
    logic         bus_busy;
    logic         ic_en;
    logic         l2_rdy;
    logic         complete;
    logic [127:0] data_wd_l2;
    logic         mem_req;
    logic [29:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    icache_refill dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .l2_addr_i    (l2_addr),
        .bus_busy_i   (bus_busy),
        .ic_en_o      (ic_en),
        .l2_rdy_o     (l2_rdy),
        .complete_o   (complete),
        .data_wd_l2_o (data_wd_l2),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed output event must match the head of the scoreboard
    always @(negedge clk) begin
        int   obs;
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event kind %0d: got none expected at cyc %0d", e.kind, e.cyc);
        end
        obs = -1;
        if (32'(mem_req) + 32'(l2_rdy) + 32'(complete) > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL overlap @cyc %0d: got req=%0b rdy=%0b cmp=%0b expected one", cyc,
                     mem_req, l2_rdy, complete);
        end else if (mem_req)  obs = K_REQ;
        else if (l2_rdy)       obs = K_RDY;
        else if (complete)     obs = K_DONE;
        if (obs >= 0) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event @cyc %0d: got kind %0d expected none", cyc, obs);
            end else begin
                e = sb.pop_front();
                chk("event_kind", 128'(obs), 128'(e.kind));
                if (e.kind == K_REQ) chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                else                 chk("data_wd_l2", data_wd_l2, e.data);
            end
        end
    end

    task automatic push(input int kind, input logic [29:0] addr, input logic [127:0] data,
                        input int c);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // One full refill starting this cycle; optionally withholds acks on one beat,
    // holds bus_busy high while the refill owns the bus, and stray-acks in RF_RDY.
    task automatic refill(input logic [27:0] a, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3, input int wbeat,
                          input int nw, input bit hold_busy, input bit stray_rdy);
        logic [31:0]  w[4];
        logic [127:0] blk;
        logic [1:0]   bb;
        int           c;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        blk  = {w3, w2, w1, w0};
        c    = cyc + 1;
        for (int b = 0; b < 4; b++) begin
            bb = 2'(b);
            for (int k = 0; k < ((b == wbeat) ? nw + 1 : 1); k++) begin
                push(K_REQ, {a, bb}, '0, c);
                c++;
            end
        end
        push(K_RDY, '0, blk, c);
        push(K_DONE, '0, blk, c + 1);
        irq = 1'b1; l2_addr = a; bus_busy = 1'b0; mem_ack = 1'b0;
        step();
        if (hold_busy) bus_busy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == wbeat) begin
                for (int k = 0; k < nw; k++) begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                    #1;
                    if (hold_busy) chk("ic_en_fetch", 128'(ic_en), 128'(1));
                    step();
                end
            end
            mem_ack = 1'b1; mem_rdata = w[b];
            step();
        end
        mem_ack = stray_rdy; mem_rdata = 32'hDEADBEEF;
        #1;
        if (hold_busy) chk("ic_en_rdy", 128'(ic_en), 128'(1));
        step();
        mem_ack = 1'b0; irq = 1'b0;
        step();
        bus_busy = 1'b0;
    endtask

    initial begin
        logic [127:0] blk_a;
        rst = 1'b1; irq = 1'b0; l2_addr = '0; bus_busy = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("rst_mem_req",  128'(mem_req),  128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_l2_rdy",   128'(l2_rdy),   128'(0));
        chk("rst_complete", 128'(complete), 128'(0));
        chk("rst_data",     data_wd_l2,     128'(0));
        chk("rst_ic_en_free", 128'(ic_en), 128'(1));
        bus_busy = 1'b1;
        #1;
        chk("rst_ic_en_busy", 128'(ic_en), 128'(0));
        rst = 1'b0; bus_busy = 1'b0;
        step();

        // Basic zero-wait refill, then a stray ack while idle
        refill(28'h0000123, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 9, 0, 0, 0);
        blk_a = 128'h44444444_33333333_22222222_11111111;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        step();
        chk("stray_idle_data", data_wd_l2, blk_a);

        // Wait states on beat 2, with bus_busy raised while the refill owns the bus
        refill(28'h0000123, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 2, 3, 1, 0);
        step();

        // Bus busy before the request: wait, address changes, then fetch at 0x800
        irq = 1'b1; bus_busy = 1'b1; l2_addr = 28'h0000123;
        #1;
        chk("busy_ic_en", 128'(ic_en), 128'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) l2_addr = 28'h0000200;
            #1;
            chk("busy_wait_ic_en", 128'(ic_en), 128'(0));
            chk("busy_wait_req", 128'(mem_req), 128'(0));
        end
        step();
        refill(28'h0000200, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 9, 0, 0, 1);
        step();

        // Reset in the middle of a fetch, after the beat 1 ack
        push(K_REQ, 30'h0000040C, '0, cyc + 1);
        push(K_REQ, 30'h0000040D, '0, cyc + 2);
        push(K_REQ, 30'h0000040E, '0, cyc + 3);
        irq = 1'b1; l2_addr = 28'h0000103;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h66666666;
        step();
        mem_ack = 1'b0; irq = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_mem_req", 128'(mem_req), 128'(0));
        chk("midrst_data",    data_wd_l2,    128'(0));
        chk("midrst_l2_rdy",  128'(l2_rdy),  128'(0));
        chk("midrst_mem_addr", 128'(mem_addr), 128'(0));
        step();
        step();
        refill(28'h0000103, 32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA, 9, 0, 0, 0);

        // Back-to-back: second request in the idle cycle right after complete
        refill(28'h0000124, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 9, 0, 0, 0);
        step();
        step();
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
